// File: rtl/yrv_intc_pkg.sv
// Shared constants, state encoding and priority helper for the YRV interrupt controller.
package yrv_intc_pkg;

  localparam int unsigned IDW    = 4;
  localparam int unsigned MAXSRC = 15;
  localparam int unsigned DW     = 16;
  localparam int unsigned AW     = 3;

  localparam logic [IDW-1:0] ID_NONE = '0;

  localparam logic [AW-1:0] INTC_PEND     = 3'd0;
  localparam logic [AW-1:0] INTC_ENABLE   = 3'd1;
  localparam logic [AW-1:0] INTC_MODE     = 3'd2;
  localparam logic [AW-1:0] INTC_CLAIM    = 3'd3;
  localparam logic [AW-1:0] INTC_COMPLETE = 3'd4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } intc_state_e;

  // Lowest set bit wins; returns its index plus one, or ID_NONE.
  function automatic logic [IDW-1:0] first_id(input logic [MAXSRC-1:0] req);
    logic [IDW-1:0] id;
    id = ID_NONE;
    for (int i = int'(MAXSRC) - 1; i >= 0; i--) begin
      if (req[i]) id = IDW'(i + 1);
    end
    return id;
  endfunction

endpackage

// File: rtl/yrv_intc_sync.sv
// Per-source 2-flop synchronizer with a history flop for rising-edge detection.
module yrv_intc_sync #(
  parameter int unsigned NSRC = 8
) (
  input  logic            clk,
  input  logic            resetb,
  input  logic [NSRC-1:0] irq_src,
  output logic [NSRC-1:0] lvl,
  output logic [NSRC-1:0] rise_c
);

  logic [NSRC-1:0] s1_q, s1_d;
  logic [NSRC-1:0] s2_q, s2_d;
  logic [NSRC-1:0] s3_q, s3_d;

  always_comb begin
    s1_d = irq_src;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign lvl    = s2_q;
  assign rise_c = s2_q & ~s3_q;

endmodule

// File: rtl/yrv_intc.sv
// Vectored interrupt controller: pending/enable/mode registers, claim/complete FSM, ei_req.
module yrv_intc
  import yrv_intc_pkg::*;
#(
  parameter int unsigned NSRC = 8
) (
  input  logic            clk,
  input  logic            resetb,
  input  logic [NSRC-1:0] irq_src,
  input  logic            reg_sel,
  input  logic            reg_wr,
  input  logic [AW-1:0]   reg_addr,
  input  logic [DW-1:0]   reg_wdata,
  output logic [DW-1:0]   reg_rdata,
  output logic            ei_req
);

  logic [NSRC-1:0] lvl, rise_c;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] enable_q, enable_d;
  logic [NSRC-1:0] mode_q, mode_d;
  logic [NSRC-1:0] w1c_mask_c, claim_mask_c;
  logic [IDW-1:0]  cand_c;
  logic [IDW-1:0]  svc_id_q, svc_id_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            ei_req_q, ei_req_d;
  logic            rd_c, wr_c, claim_c, complete_c;
  logic            wdata_unused_c;
  intc_state_e     state_q, state_d;

  yrv_intc_sync #(.NSRC(NSRC)) u_sync (
    .clk     (clk),
    .resetb  (resetb),
    .irq_src (irq_src),
    .lvl     (lvl),
    .rise_c  (rise_c)
  );

  assign rd_c           = reg_sel & ~reg_wr;
  assign wr_c           = reg_sel & reg_wr;
  assign cand_c         = first_id(MAXSRC'(pend_q & enable_q));
  assign claim_c        = rd_c && (reg_addr == INTC_CLAIM) && (state_q == REQ) && (cand_c != ID_NONE);
  assign complete_c     = wr_c && (reg_addr == INTC_COMPLETE) && (reg_wdata[IDW-1:0] == svc_id_q);
  assign wdata_unused_c = ^reg_wdata;

  // Register writes, pending update and read mux.
  always_comb begin
    enable_d     = enable_q;
    mode_d       = mode_q;
    w1c_mask_c   = '0;
    claim_mask_c = '0;
    rdata_d      = rdata_q;
    if (wr_c) begin
      case (reg_addr)
        INTC_PEND:   w1c_mask_c = reg_wdata[NSRC-1:0];
        INTC_ENABLE: enable_d   = reg_wdata[NSRC-1:0];
        INTC_MODE:   mode_d     = reg_wdata[NSRC-1:0];
        default:     ;
      endcase
    end
    for (int i = 0; i < int'(NSRC); i++) begin
      if (claim_c && (cand_c == IDW'(i + 1))) claim_mask_c[i] = 1'b1;
    end
    // Edge sources: a new edge beats a same-cycle clear. Level sources track s2.
    pend_d = (mode_q & ((pend_q & ~(w1c_mask_c | claim_mask_c)) | rise_c)) | (~mode_q & lvl);
    if (rd_c) begin
      case (reg_addr)
        INTC_PEND:   rdata_d = DW'(pend_q);
        INTC_ENABLE: rdata_d = DW'(enable_q);
        INTC_MODE:   rdata_d = DW'(mode_q);
        INTC_CLAIM:  rdata_d = DW'(cand_c);
        default:     rdata_d = '0;
      endcase
    end
  end

  // Claim/complete state machine.
  always_comb begin
    state_d  = state_q;
    svc_id_d = svc_id_q;
    case (state_q)
      IDLE: begin
        if (cand_c != ID_NONE) state_d = REQ;
      end
      REQ: begin
        if (cand_c == ID_NONE) begin
          state_d = IDLE;
        end else if (claim_c) begin
          state_d  = SERVICE;
          svc_id_d = cand_c;
        end
      end
      SERVICE: begin
        if (complete_c) begin
          state_d  = IDLE;
          svc_id_d = ID_NONE;
        end
      end
      default: state_d = IDLE;
    endcase
    ei_req_d = (state_d == REQ);
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      pend_q   <= '0;
      enable_q <= '0;
      mode_q   <= '0;
      rdata_q  <= '0;
      svc_id_q <= ID_NONE;
      state_q  <= IDLE;
      ei_req_q <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      enable_q <= enable_d;
      mode_q   <= mode_d;
      rdata_q  <= rdata_d;
      svc_id_q <= svc_id_d;
      state_q  <= state_d;
      ei_req_q <= ei_req_d;
    end
  end

  assign reg_rdata = rdata_q;
  assign ei_req    = ei_req_q;

endmodule
